// File: rtl/dram_port_arbiter.sv
// Two-port burst arbiter in front of a single-port DRAM with a 1-cycle registered read.
// Port 0 is the NPU load/store path and port 1 is the host loader. One burst runs
// at a time and ownership alternates round-robin when both ports ask together.
// Read data is returned on a shared bus tagged with a per-port valid.
module dram_port_arbiter #(
    parameter int AWIDTH    = 10,
    parameter int DWIDTH    = 80,
    parameter int LEN_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_npu,
    input  logic                 npu_req,
    input  logic                 npu_we,
    input  logic [AWIDTH-1:0]    npu_addr,
    input  logic [LEN_WIDTH-1:0] npu_len,
    input  logic [DWIDTH-1:0]    npu_wdata,
    output logic                 npu_start,
    output logic                 npu_beat,
    output logic                 npu_rvalid,
    input  logic                 host_req,
    input  logic                 host_we,
    input  logic [AWIDTH-1:0]    host_addr,
    input  logic [LEN_WIDTH-1:0] host_len,
    input  logic [DWIDTH-1:0]    host_wdata,
    output logic                 host_start,
    output logic                 host_beat,
    output logic                 host_rvalid,
    output logic [DWIDTH-1:0]    rdata,
    output logic [AWIDTH-1:0]    dram_addr,
    output logic [DWIDTH-1:0]    dram_wdata,
    output logic                 dram_we,
    input  logic [DWIDTH-1:0]    dram_rdata,
    output logic                 busy
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    logic [0:0]           state_r;
    logic                 owner_r;       // 0 = npu, 1 = host
    logic                 we_r;
    logic                 last_host_r;   // 1 when the host held the most recent grant
    logic [AWIDTH-1:0]    base_r;
    logic [LEN_WIDTH-1:0] len_r;
    logic [LEN_WIDTH-1:0] cnt_r;
    logic                 npu_rvalid_r;
    logic                 host_rvalid_r;

    logic                 grant_npu_s;
    logic                 grant_host_s;
    logic                 in_burst_s;

    assign in_burst_s = (state_r == ST_BURST);

    // Arbitration in IDLE: a lone requester always wins, a tie goes to the port not granted last.
    always_comb begin
        grant_npu_s  = 1'b0;
        grant_host_s = 1'b0;
        if (state_r == ST_IDLE) begin
            if (npu_req && (!host_req || last_host_r)) begin
                grant_npu_s = 1'b1;
            end else if (host_req) begin
                grant_host_s = 1'b1;
            end else begin
                grant_npu_s  = 1'b0;
                grant_host_s = 1'b0;
            end
        end else begin
            grant_npu_s  = 1'b0;
            grant_host_s = 1'b0;
        end
    end

    // Burst sequencer: capture the winner's request, then walk beat_cnt up to len.
    always_ff @(posedge clk or posedge reset_npu) begin
        if (reset_npu) begin
            state_r     <= ST_IDLE;
            owner_r     <= 1'b0;
            we_r        <= 1'b0;
            base_r      <= '0;
            len_r       <= '0;
            cnt_r       <= '0;
            last_host_r <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_npu_s || grant_host_s) begin
                        state_r     <= ST_BURST;
                        owner_r     <= grant_host_s;
                        we_r        <= grant_host_s ? host_we   : npu_we;
                        base_r      <= grant_host_s ? host_addr : npu_addr;
                        len_r       <= grant_host_s ? host_len  : npu_len;
                        cnt_r       <= '0;
                        last_host_r <= grant_host_s;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BURST: begin
                    if (cnt_r == len_r) begin
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + {{(LEN_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Read-return tag: one stage behind the beat, matching the DRAM read latency.
    always_ff @(posedge clk or posedge reset_npu) begin
        if (reset_npu) begin
            npu_rvalid_r  <= 1'b0;
            host_rvalid_r <= 1'b0;
        end else begin
            npu_rvalid_r  <= in_burst_s && !we_r && !owner_r;
            host_rvalid_r <= in_burst_s && !we_r && owner_r;
        end
    end

    // DRAM side drive: address, data and write enable only while a burst is running.
    always_comb begin
        if (in_burst_s) begin
            dram_addr  = base_r + AWIDTH'(cnt_r);
            dram_wdata = owner_r ? host_wdata : npu_wdata;
            dram_we    = we_r;
        end else begin
            dram_addr  = '0;
            dram_wdata = '0;
            dram_we    = 1'b0;
        end
    end

    // Returned read data comes straight off the DRAM output register, zero when untagged.
    always_comb begin
        if (npu_rvalid_r || host_rvalid_r) begin
            rdata = dram_rdata;
        end else begin
            rdata = '0;
        end
    end

    assign busy        = in_burst_s;
    assign npu_start   = grant_npu_s;
    assign host_start  = grant_host_s;
    assign npu_beat    = in_burst_s && !owner_r;
    assign host_beat   = in_burst_s && owner_r;
    assign npu_rvalid  = npu_rvalid_r;
    assign host_rvalid = host_rvalid_r;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Bench for dram_port_arbiter: directed scenarios followed by random two-port traffic,
// all checked cycle by cycle against a transaction-level model (queue of pending beats,
// a shadow memory and a one-entry read-return slot).
module tb_dram_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 80;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          reset_npu;
    logic          npu_req, npu_we, host_req, host_we;
    logic [AW-1:0] npu_addr, host_addr;
    logic [LW-1:0] npu_len, host_len;
    logic [DW-1:0] npu_wdata, host_wdata;
    logic          npu_start, npu_beat, npu_rvalid;
    logic          host_start, host_beat, host_rvalid;
    logic [DW-1:0] rdata, dram_wdata, dram_rdata;
    logic [AW-1:0] dram_addr;
    logic          dram_we, busy;

    dram_port_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .reset_npu(reset_npu),
        .npu_req(npu_req), .npu_we(npu_we), .npu_addr(npu_addr), .npu_len(npu_len),
        .npu_wdata(npu_wdata), .npu_start(npu_start), .npu_beat(npu_beat), .npu_rvalid(npu_rvalid),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_len(host_len),
        .host_wdata(host_wdata), .host_start(host_start), .host_beat(host_beat), .host_rvalid(host_rvalid),
        .rdata(rdata), .dram_addr(dram_addr), .dram_wdata(dram_wdata), .dram_we(dram_we),
        .dram_rdata(dram_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // DRAM model: synchronous write, one-cycle registered read.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (dram_we) mem[dram_addr] <= dram_wdata;
        dram_rdata <= mem[dram_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] init_word(input int a);
        logic [DW-1:0] w;
        w = {16'hC0DE, 54'h0, 10'(a)};
        return w;
    endfunction

    function automatic logic [DW-1:0] rand80();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    // ---------------- reference model ----------------
    typedef struct {bit port; bit we; logic [AW-1:0] addr;} beat_t;
    beat_t         bq[$];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    bit            ret_v;
    bit            ret_port;
    logic [DW-1:0] ret_data;
    bit            m_last_host;

    logic [DW-1:0] npu_cap[$];
    int            dut_grants[$];
    int            n_nbeat, n_nstart;

    task automatic model_flush();
        bq.delete();
        ret_v       = 1'b0;
        m_last_host = 1'b1;
    endtask

    // One cycle: called just after a posedge with inputs already driven; checks and
    // advances to just after the next posedge.
    task automatic check_cycle();
        bit e_ns, e_hs, e_nb, e_hb, e_busy, e_we, e_nrv, e_hrv;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd, e_rd;
        int w;
        beat_t b;
        #1;
        e_ns = 0; e_hs = 0; e_nb = 0; e_hb = 0; e_busy = 0; e_we = 0;
        e_addr = '0; e_wd = '0;
        e_nrv = ret_v && !ret_port;
        e_hrv = ret_v && ret_port;
        e_rd  = ret_data;
        ret_v = 1'b0;
        if (bq.size() == 0) begin
            w = -1;
            if (npu_req && host_req) w = m_last_host ? 0 : 1;
            else if (npu_req)        w = 0;
            else if (host_req)       w = 1;
            if (w >= 0) begin
                m_last_host = (w == 1);
                if (w == 0) e_ns = 1; else e_hs = 1;
                for (int i = 0; i <= int'(w ? host_len : npu_len); i++) begin
                    b.port = (w == 1);
                    b.we   = w ? host_we : npu_we;
                    b.addr = (w ? host_addr : npu_addr) + AW'(i);
                    bq.push_back(b);
                end
            end
        end else begin
            b = bq.pop_front();
            e_busy = 1; e_addr = b.addr; e_we = b.we;
            e_wd = b.port ? host_wdata : npu_wdata;
            if (b.port) e_hb = 1; else e_nb = 1;
            if (b.we) ref_mem[b.addr] = e_wd;
            else begin
                ret_v = 1'b1; ret_port = b.port; ret_data = ref_mem[b.addr];
            end
        end
        check("npu_start", npu_start, e_ns);
        check("host_start", host_start, e_hs);
        check("npu_beat", npu_beat, e_nb);
        check("host_beat", host_beat, e_hb);
        check("busy", busy, e_busy);
        check("dram_we", dram_we, e_we);
        check("dram_addr", dram_addr, e_addr);
        check("dram_wdata", dram_wdata, e_wd);
        check("npu_rvalid", npu_rvalid, e_nrv);
        check("host_rvalid", host_rvalid, e_hrv);
        if (e_nrv || e_hrv) check("rdata", rdata, e_rd);
        if (npu_rvalid) npu_cap.push_back(rdata);
        if (npu_start)  dut_grants.push_back(0);
        if (host_start) dut_grants.push_back(1);
        if (npu_beat)   n_nbeat++;
        if (npu_start)  n_nstart++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        npu_req = 0; host_req = 0; npu_we = 0; host_we = 0;
    endtask

    // Reset applied from just after a posedge; outputs must drop in the same cycle.
    task automatic do_reset();
        reset_npu = 1'b1;
        idle_inputs();
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_dram_we", dram_we, 1'b0);
        check("rst_dram_addr", dram_addr, '0);
        check("rst_beats", {npu_beat, host_beat}, 2'b00);
        check("rst_rvalid", {npu_rvalid, host_rvalid}, 2'b00);
        check("rst_rdata", rdata, '0);
        model_flush();
        check_cycle();
        check_cycle();
        reset_npu = 1'b0;
    endtask

    task automatic req_npu(input bit we, input int addr, input int len);
        npu_req = 1; npu_we = we; npu_addr = AW'(addr); npu_len = LW'(len);
    endtask

    task automatic req_host(input bit we, input int addr, input int len);
        host_req = 1; host_we = we; host_addr = AW'(addr); host_len = LW'(len);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]     = init_word(i);
            ref_mem[i] = init_word(i);
        end
        reset_npu = 1'b1;
        idle_inputs();
        npu_addr = '0; npu_len = '0; host_addr = '0; host_len = '0;
        npu_wdata = '0; host_wdata = '0;
        model_flush();
        #3;
        check("reset_outputs",
              {npu_start, npu_beat, npu_rvalid, host_start, host_beat, host_rvalid, dram_we, busy},
              8'h00);
        check("reset_dram_addr", dram_addr, '0);
        check("reset_rdata", rdata, '0);
        @(posedge clk); #1;
        reset_npu = 1'b0;

        // Read burst of 4 from 0x010.
        npu_cap.delete();
        req_npu(0, 'h010, 3);
        check_cycle();
        npu_req = 0;
        repeat (6) check_cycle();
        check("t1_count", npu_cap.size(), 4);
        for (int i = 0; i < 4; i++)
            check("t1_data", (npu_cap.size() > i) ? npu_cap[i] : '0, init_word('h010 + i));

        // Host write wrapping past the top of memory, then readback.
        req_host(1, 'h3FE, 2);
        check_cycle();
        host_req = 0;
        host_wdata = 80'hA; check_cycle();
        host_wdata = 80'hB; check_cycle();
        host_wdata = 80'hC; check_cycle();
        check_cycle();
        check("t2_wrap_mem", mem[0], 80'hC);
        npu_cap.delete();
        req_npu(0, 'h3FE, 2);
        check_cycle();
        npu_req = 0;
        repeat (5) check_cycle();
        check("t2_rb_count", npu_cap.size(), 3);
        check("t2_rb0", (npu_cap.size() > 0) ? npu_cap[0] : '0, 80'hA);
        check("t2_rb1", (npu_cap.size() > 1) ? npu_cap[1] : '0, 80'hB);
        check("t2_rb2", (npu_cap.size() > 2) ? npu_cap[2] : '0, 80'hC);

        // Contention after reset: grants alternate npu, host, npu.
        do_reset();
        dut_grants.delete();
        req_npu(0, 'h020, 0);
        req_host(0, 'h030, 0);
        for (int k = 0; k < 20 && dut_grants.size() < 3; k++) check_cycle();
        idle_inputs();
        repeat (3) check_cycle();
        check("t3_ngrants", dut_grants.size(), 3);
        check("t3_g0", (dut_grants.size() > 0) ? dut_grants[0] : 9, 0);
        check("t3_g1", (dut_grants.size() > 1) ? dut_grants[1] : 9, 1);
        check("t3_g2", (dut_grants.size() > 2) ? dut_grants[2] : 9, 0);

        // Npu return overlapping IDLE while host is being granted.
        npu_cap.delete();
        req_npu(0, 'h040, 0);
        check_cycle();
        npu_req = 0;
        req_host(0, 'h050, 0);
        check_cycle();
        check_cycle();
        host_req = 0;
        repeat (3) check_cycle();
        check("t4_npu_cap", (npu_cap.size() == 1) ? npu_cap[0] : '0, init_word('h040));

        // Reset in the middle of an 8-beat write.
        req_npu(1, 'h200, 7);
        check_cycle();
        npu_req = 0;
        for (int i = 0; i < 4; i++) begin
            npu_wdata = 80'h5500 + 80'(i);
            check_cycle();
        end
        do_reset();
        for (int i = 4; i < 8; i++) check("t5_untouched", mem['h200 + i], init_word('h200 + i));
        check("t5_beat3", mem['h203], 80'h5503);
        dut_grants.delete();
        req_npu(0, 'h060, 0);
        req_host(0, 'h070, 0);
        check_cycle();
        idle_inputs();
        check("t5_first_grant", (dut_grants.size() > 0) ? dut_grants[0] : 9, 0);
        repeat (3) check_cycle();

        // Request dropped right after start: burst still completes, no second start.
        n_nbeat = 0; n_nstart = 0;
        req_npu(0, 'h080, 5);
        check_cycle();
        npu_req = 0;
        repeat (10) check_cycle();
        check("t6_beats", n_nbeat, 6);
        check("t6_starts", n_nstart, 1);

        // Random traffic on both ports.
        for (int c = 0; c < 2000; c++) begin
            npu_wdata  = rand80();
            host_wdata = rand80();
            if (npu_start) begin
                if ($urandom_range(1) == 0) npu_req = 0;
                else req_npu($urandom_range(1), $urandom_range(1023), $urandom_range(15));
            end else if (!npu_req && $urandom_range(2) == 0) begin
                req_npu($urandom_range(1), $urandom_range(1023), $urandom_range(15));
            end
            if (host_start) begin
                if ($urandom_range(1) == 0) host_req = 0;
                else req_host($urandom_range(1), $urandom_range(1023), $urandom_range(15));
            end else if (!host_req && $urandom_range(2) == 0) begin
                req_host($urandom_range(1), $urandom_range(1023), $urandom_range(15));
            end
            // Sample start of the cycle about to be checked from the driven inputs next time.
            check_cycle();
        end
        idle_inputs();
        repeat (25) check_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
